// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write sub-word stores
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [8:0]  addr_q;     // bits above 8 are only needed for the range check at acceptance
  logic [15:0] wdata_q;    // only the low halfword feeds the sub-word merge; SW data goes straight out

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [6:0]  mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        legal_f3;
  logic        misaligned;
  logic        req_err;
  logic        needs_read;
  logic [4:0]  lane_sh;
  logic [31:0] lane_word;
  logic [31:0] load_ext;
  logic [31:0] merge_mask;
  logic [31:0] merged_word;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Classify the incoming request: legality of funct3 for its direction, alignment and range
  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    if (req_write) begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    if (req_funct3[1:0] == 2'b01) misaligned = req_addr[0];
    if (req_funct3[1:0] == 2'b10) misaligned = (req_addr[1:0] != 2'b00);
    req_err    = !legal_f3 || misaligned || (req_addr[31:9] != 23'd0);
    // Loads and sub-word stores both need the current word first
    needs_read = !req_write || (req_funct3 != 3'b010);
  end

  // Lane selection, load extension and sub-word store merge from the captured request
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_word = mem_rdata >> lane_sh;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_ext = {24'd0, lane_word[7:0]};
      3'b101:  load_ext = {16'd0, lane_word[15:0]};
      default: load_ext = mem_rdata;
    endcase
    merge_mask  = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh;
    merged_word = (mem_rdata & ~merge_mask) | (({16'd0, wdata_q} << lane_sh) & merge_mask);
  end

  // Sequencer: all outputs are registered and set on the transition into the state that owns them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 9'd0;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 7'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[8:0];
            wdata_q  <= req_wdata[15:0];
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else if (needs_read) begin
              state_q    <= S_RD;
              mem_read_q <= 1'b1;
              mem_addr_q <= req_addr[8:2];
            end else begin
              state_q     <= S_WR_SETUP;
              mem_addr_q  <= req_addr[8:2];
              mem_wdata_q <= req_wdata;
            end
          end
        end
        S_RD: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            state_q     <= S_WR_SETUP;
            mem_wdata_q <= merged_word;
          end else begin
            state_q      <= S_RESP;
            mem_addr_q   <= 7'd0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_ext;
          end
        end
        S_WR_SETUP: begin
          state_q     <= S_WR_PULSE;
          mem_write_q <= 1'b1;
        end
        S_WR_PULSE: begin
          state_q     <= S_WR_HOLD;
          mem_write_q <= 1'b0;
        end
        S_WR_HOLD: begin
          state_q      <= S_RESP;
          mem_addr_q   <= 7'd0;
          mem_wdata_q  <= 32'd0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          wr_pulses = 0;
  int          resp_count = 0;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];

  always @(posedge mem_write) begin
    mem[mem_addr] = mem_wdata;
    wr_pulses = wr_pulses + 1;
  end

  always @(negedge clk) if (resp_valid) resp_count <= resp_count + 1;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          reads;
    int          writes;
    int          widx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nr, output int nw, output int pk);
    lat = 0; rd = 32'd0; er = 1'b0; nr = 0; nw = 0; pk = 0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request inputs after acceptance; the unit must use its captured copy
    req_valid = 1'b0; req_write = ~wr; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 12; k++) begin
      if (mem_read) nr++;
      if (mem_write) begin nw++; pk = k; end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nr, nw, pk;
    logic [31:0] rd;
    logic er;
    int wp0, rc0, a1, r1, a2, r2;
    logic [31:0] rd1, rd2;

    for (int i = 0; i < 128; i++) mem[i] = i;

    //           wr    f3      addr          wdata         lat rdata         err  rd wr widx word
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        2, 32'h0000_0004, 1'b0, 1, 0, -1, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h1234_56AB, 5, 32'h0,        1'b0, 1, 1, 1,  32'h0000_AB01};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0005, 32'h0,        2, 32'hFFFF_FFAB, 1'b0, 1, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h0000_0005, 32'h0,        2, 32'h0000_00AB, 1'b0, 1, 0, -1, 32'h0};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_000A, 32'h0000_8001, 5, 32'h0,        1'b0, 1, 1, 2,  32'h8001_0002};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_000A, 32'h0,        2, 32'hFFFF_8001, 1'b0, 1, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0008, 32'h0,        2, 32'h0000_0002, 1'b0, 1, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0003, 32'h0,        1, 32'h0,        1'b1, 0, 0, -1, 32'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        1, 32'h0,        1'b1, 0, 0, -1, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_000C, 32'hDEAD_BEEF, 4, 32'h0,        1'b0, 0, 1, 3,  32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_000C, 32'h0,        2, 32'hDEAD_BEEF, 1'b0, 1, 0, -1, 32'h0};
    vecs[11] = '{1'b0, 3'b000, 32'h0000_000F, 32'h0,        2, 32'hFFFF_FFDE, 1'b0, 1, 0, -1, 32'h0};
    vecs[12] = '{1'b0, 3'b101, 32'h0000_000E, 32'h0,        2, 32'h0000_DEAD, 1'b0, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111, 1, 32'h0,        1'b1, 0, 0, 4,  32'h0000_0004};
    vecs[14] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,        1, 32'h0,        1'b1, 0, 0, -1, 32'h0};
    vecs[15] = '{1'b1, 3'b000, 32'h0000_01FF, 32'h0000_007F, 5, 32'h0,        1'b0, 1, 1, 127, 32'h7F00_007F};
    vecs[16] = '{1'b0, 3'b010, 32'h0000_01FC, 32'h0,        2, 32'h7F00_007F, 1'b0, 1, 0, -1, 32'h0};
    vecs[17] = '{1'b0, 3'b000, 32'h0000_0004, 32'h0,        2, 32'h0000_0001, 1'b0, 1, 0, -1, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 18; v++) begin
      run_req(vecs[v].wr, vecs[v].f3, vecs[v].addr, vecs[v].wdata, lat, rd, er, nr, nw, pk);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
      chk($sformatf("v%0d_err", v), {31'd0, er}, {31'd0, vecs[v].err});
      chk($sformatf("v%0d_read_cycles", v), nr, vecs[v].reads);
      chk($sformatf("v%0d_write_pulses", v), nw, vecs[v].writes);
      if (vecs[v].writes == 1) chk($sformatf("v%0d_pulse_cycle", v), pk, vecs[v].lat - 2);
      if (vecs[v].widx >= 0) chk($sformatf("v%0d_word", v), mem[vecs[v].widx], vecs[v].word);
      chk($sformatf("v%0d_ready_after", v), {31'd0, req_ready}, 32'd1);
    end

    // Reset during WR_SETUP: no pulse, no response, word untouched
    wp0 = wr_pulses; rc0 = resp_count;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0020; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("setup_rst_mem_write", {31'd0, mem_write}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("setup_rst_pulses", wr_pulses - wp0, 32'd0);
    chk("setup_rst_resp", resp_count - rc0, 32'd0);
    chk("setup_rst_word8", mem[8], 32'd8);
    chk("setup_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("setup_rst_mem_addr", {25'd0, mem_addr}, 32'd0);

    // Reset during WR_PULSE: strobe drops at the reset edge, no response
    rc0 = resp_count;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0024; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pulse_rst_pulse_high", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("pulse_rst_mem_write", {31'd0, mem_write}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("pulse_rst_resp", resp_count - rc0, 32'd0);
    chk("pulse_rst_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back loads with req_valid held high
    a1 = -1; r1 = -1; a2 = -1; r2 = -1; rd1 = 32'd0; rd2 = 32'd0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0010;
    if (req_ready) a1 = cyc;
    @(posedge clk); #1;
    req_addr = 32'h0000_0014;
    for (int k = 0; k < 20; k++) begin
      if (a2 >= 0 && cyc > a2) req_valid = 1'b0;
      if (resp_valid && r1 < 0) begin r1 = cyc; rd1 = resp_rdata; end
      else if (resp_valid && a2 >= 0 && r2 < 0) begin r2 = cyc; rd2 = resp_rdata; end
      if (req_ready && req_valid && r1 >= 0 && a2 < 0) a2 = cyc;
      if (r2 >= 0) break;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_first_resp_cycle", r1 - a1, 32'd2);
    chk("b2b_first_rdata", rd1, 32'h0000_0004);
    chk("b2b_second_accept", a2 - r1, 32'd1);
    chk("b2b_second_resp_cycle", r2 - a2, 32'd2);
    chk("b2b_second_rdata", rd2, 32'h0000_0005);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
